lsu_latency_dcache: RTL and testbench

Behavioural data-cache model that sits directly downstream of the LSU load/store queue. It consumes the LSQ's dcache request channel and returns in-order responses tagged with the LSQ index after a programmable latency. It holds a word-addressed backing memory, so store-to-load sequences can be checked end to end. It is used in LSU-level simulation benches in place of the real L1D; it is not synthesis-targeted, but it must be fully synchronous RTL.

---
 rtl/lsu_latency_dcache.sv | 145 ++++++++++++++
 tb/tb_lsu_latency_dcache.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_latency_dcache.sv
// Latency-programmable behavioural L1D stand-in for the LSU queue: word-addressed backing memory, in-order tagged responses.
// Optional build macro LSU_DCACHE_RAND_LAT_EN adds 0..3 cycles of LFSR-driven jitter to each entry's latency.
module lsu_latency_dcache #(
    parameter int XLEN    = 64,
    parameter int ADDR_W  = 39,
    parameter int IDX_W   = 3,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2,
    parameter int MEM_DW  = 1024
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_opcode_i,
    input  logic              req_sign_i,
    input  logic [1:0]        req_size_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [XLEN-1:0]   req_data_i,
    input  logic [IDX_W-1:0]  req_lsq_index_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [XLEN-1:0]   resp_data_o,
    output logic [IDX_W-1:0]  resp_lsq_index_o,
    output logic              resp_store_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ROW_W = $clog2(MEM_DW);

    logic [XLEN-1:0]  mem [MEM_DW];

    logic             ent_valid [DEPTH];
    logic             ent_store [DEPTH];
    logic [IDX_W-1:0] ent_tag   [DEPTH];
    logic [XLEN-1:0]  ent_data  [DEPTH];
    logic [3:0]       ent_timer [DEPTH];

    logic [PTR_W-1:0] head, tail;
    logic [PTR_W:0]   count;
    logic             push, pop;
    logic [3:0]       lat_load;

    logic [ROW_W-1:0] row;
    logic [2:0]       size_m1, off;
    logic [5:0]       shamt;
    logic [XLEN-1:0]  size_mask, wr_mask, wr_data, rd_raw, ld_data;
    logic             unused_addr;

    assign unused_addr = ^req_addr_i[ADDR_W-1:ROW_W+3];

    // Both channels use plain valid/ready: a transfer happens on a rising edge where valid and ready are both high;
    // req_ready_o depends only on occupancy, and resp_* stay stable while resp_valid_o waits for resp_ready_i.
    assign req_ready_o = (count != (PTR_W+1)'(DEPTH));
    assign push        = req_valid_i && req_ready_o;
    assign resp_valid_o     = ent_valid[head] && (ent_timer[head] == 4'd0);
    assign pop              = resp_valid_o && resp_ready_i;
    assign resp_data_o      = resp_valid_o ? ent_data[head] : '0;
    assign resp_lsq_index_o = resp_valid_o ? ent_tag[head]  : '0;
    assign resp_store_o     = resp_valid_o && ent_store[head];

    // Misaligned offsets silently round down to the access size.
    always_comb begin
        size_m1   = 3'd7;
        size_mask = '1;
        case (req_size_i)
            2'd0: begin size_m1 = 3'd0; size_mask = XLEN'(8'hFF);        end
            2'd1: begin size_m1 = 3'd1; size_mask = XLEN'(16'hFFFF);     end
            2'd2: begin size_m1 = 3'd3; size_mask = XLEN'(32'hFFFF_FFFF); end
            default: ;
        endcase
        off     = req_addr_i[2:0] & ~size_m1;
        row     = req_addr_i[ROW_W+2:3];
        shamt   = {off, 3'b000};
        wr_mask = size_mask << shamt;
        wr_data = req_data_i << shamt;
        rd_raw  = mem[row] >> shamt;
        case (req_size_i)
            2'd0:    ld_data = {{(XLEN-8){req_sign_i & rd_raw[7]}}, rd_raw[7:0]};
            2'd1:    ld_data = {{(XLEN-16){req_sign_i & rd_raw[15]}}, rd_raw[15:0]};
            2'd2:    ld_data = {{(XLEN-32){req_sign_i & rd_raw[31]}}, rd_raw[31:0]};
            default: ld_data = rd_raw;
        endcase
    end

    // Stores commit at accept, so any later load already sees them; memory is deliberately never reset.
    always_ff @(posedge clk) begin
        if (push && req_opcode_i) begin
            mem[row] <= (mem[row] & ~wr_mask) | (wr_data & wr_mask);
        end
    end

`ifdef LSU_DCACHE_RAND_LAT_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lfsr <= 8'hA5;
        end else if (push) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign lat_load = 4'(LATENCY) + {2'b00, lfsr[1:0]};
`else
    assign lat_load = 4'(LATENCY);
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_valid[i] <= 1'b0;
                ent_store[i] <= 1'b0;
                ent_tag[i]   <= '0;
                ent_data[i]  <= '0;
                ent_timer[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_valid[i] && (ent_timer[i] != 4'd0)) begin
                    ent_timer[i] <= ent_timer[i] - 4'd1;
                end
            end
            if (pop) begin
                ent_valid[head] <= 1'b0;
                head            <= head + PTR_W'(1);
            end
            if (push) begin
                ent_valid[tail] <= 1'b1;
                ent_store[tail] <= req_opcode_i;
                ent_tag[tail]   <= req_lsq_index_i;
                ent_data[tail]  <= req_opcode_i ? '0 : ld_data;
                ent_timer[tail] <= lat_load;
                tail            <= tail + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + (PTR_W+1)'(1);
            end else if (!push && pop) begin
                count <= count - (PTR_W+1)'(1);
            end
        end
    end
endmodule

// File: tb/tb_lsu_latency_dcache.sv
// Directed bench for lsu_latency_dcache: per-response scoreboard (tag, store flag, data, latency) plus occupancy/hold/reset checks.
module tb_lsu_latency_dcache;
    localparam int LAT = 2;
    localparam int EW  = 69;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_opcode_i = 1'b0;
    logic        req_sign_i = 1'b0;
    logic [1:0]  req_size_i = 2'd0;
    logic [38:0] req_addr_i = '0;
    logic [63:0] req_data_i = '0;
    logic [2:0]  req_lsq_index_i = '0;
    logic        resp_valid_o;
    logic        resp_ready_i = 1'b1;
    logic [63:0] resp_data_o;
    logic [2:0]  resp_lsq_index_o;
    logic        resp_store_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pops = 0;
    int pops_before = 0;
    int last_acc = 0;
    int pop_edge = 0;
    bit lat_chk = 1'b1;

    // entry layout: {check_latency, store, tag[2:0], data[63:0]}
    logic [EW-1:0] exp_q[$];
    int            acc_q[$];
    logic [EW-1:0] mon_e;
    int            mon_a;

    lsu_latency_dcache dut (
        .clk              (clk),
        .rstn             (rstn),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_opcode_i     (req_opcode_i),
        .req_sign_i       (req_sign_i),
        .req_size_i       (req_size_i),
        .req_addr_i       (req_addr_i),
        .req_data_i       (req_data_i),
        .req_lsq_index_i  (req_lsq_index_i),
        .resp_valid_o     (resp_valid_o),
        .resp_ready_i     (resp_ready_i),
        .resp_data_o      (resp_data_o),
        .resp_lsq_index_o (resp_lsq_index_o),
        .resp_store_o     (resp_store_o)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // driver: called just after a rising edge, returns just after the accepting edge
    task automatic send(input logic op, input logic sgn, input logic [1:0] sz, input logic [38:0] addr,
                        input logic [63:0] data, input logic [2:0] tag, input logic [63:0] exp_data);
        int n = 0;
        req_valid_i     = 1'b1;
        req_opcode_i    = op;
        req_sign_i      = sgn;
        req_size_i      = sz;
        req_addr_i      = addr;
        req_data_i      = data;
        req_lsq_index_i = tag;
        @(negedge clk);
        while (!req_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready_o) begin
            check("req_timeout", 64'(req_ready_o), 64'(1));
        end else begin
            exp_q.push_back({lat_chk, op, tag, exp_data});
            acc_q.push_back(cyc + 1);
            last_acc = cyc + 1;
        end
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    // scoreboard: every popped response is matched against the oldest expected entry
    always @(negedge clk) begin
        if (rstn && resp_valid_o && resp_ready_i) begin
            pops++;
            if (exp_q.size() == 0) begin
                check("unexpected_resp", 64'(1), 64'(0));
            end else begin
                mon_e = exp_q.pop_front();
                mon_a = acc_q.pop_front();
                check("resp_tag", 64'(resp_lsq_index_o), 64'(mon_e[66:64]));
                check("resp_store", 64'(resp_store_o), 64'(mon_e[67]));
                check("resp_data", resp_data_o, mon_e[63:0]);
                if (mon_e[68]) begin
`ifdef LSU_DCACHE_RAND_LAT_EN
                    check("resp_lat_range", 64'((cyc - mon_a >= LAT) && (cyc - mon_a <= LAT + 3)), 64'(1));
`else
                    check("resp_lat", 64'(cyc - mon_a), 64'(LAT));
`endif
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(req_ready_o), 64'(1));
        check("rst_valid", 64'(resp_valid_o), 64'(0));
        check("rst_data", resp_data_o, 64'h0);
        check("rst_tag", 64'(resp_lsq_index_o), 64'(0));
        check("rst_store", 64'(resp_store_o), 64'(0));
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // store then load doubleword, back to back
        send(1'b1, 1'b0, 2'd3, 39'h100, 64'h1122_3344_5566_7788, 3'd1, 64'h0);
        send(1'b0, 1'b0, 2'd3, 39'h100, 64'h0, 3'd5, 64'h1122_3344_5566_7788);
        wait_drain();

        // sub-word stores/loads, sign extension, alignment and aliasing
        send(1'b1, 1'b0, 2'd0, 39'h103, 64'h80, 3'd2, 64'h0);
        send(1'b0, 1'b1, 2'd0, 39'h103, 64'h0, 3'd3, 64'hFFFF_FFFF_FFFF_FF80);
        send(1'b0, 1'b0, 2'd0, 39'h103, 64'h0, 3'd4, 64'h0000_0000_0000_0080);
        send(1'b0, 1'b1, 2'd1, 39'h103, 64'h0, 3'd6, 64'hFFFF_FFFF_FFFF_8066);
        send(1'b0, 1'b0, 2'd2, 39'h100, 64'h0, 3'd7, 64'h0000_0000_8066_7788);
        send(1'b0, 1'b1, 2'd2, 39'h100, 64'h0, 3'd0, 64'hFFFF_FFFF_8066_7788);
        send(1'b1, 1'b0, 2'd3, 39'h108, 64'h0, 3'd1, 64'h0);
        send(1'b1, 1'b0, 2'd1, 39'h109, 64'hFFFF_ABCD, 3'd2, 64'h0);
        send(1'b1, 1'b0, 2'd2, 39'h10C, 64'h1_DEAD_BEEF, 3'd3, 64'h0);
        send(1'b0, 1'b0, 2'd3, 39'h108, 64'h0, 3'd4, 64'hDEAD_BEEF_0000_ABCD);
        send(1'b0, 1'b0, 2'd3, 39'h2108, 64'h0, 3'd5, 64'hDEAD_BEEF_0000_ABCD);
        send(1'b0, 1'b1, 2'd2, 39'h10C, 64'h0, 3'd6, 64'hFFFF_FFFF_DEAD_BEEF);
        wait_drain();

        // fill with consumer stalled, hold outputs, single pop, fifth accept after first pop
        lat_chk = 1'b0;
        resp_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(1'b0, 1'b0, 2'd3, 39'h100, 64'h0, 3'(i), 64'h1122_3344_8066_7788);
        end
        @(negedge clk);
        check("ready_full", 64'(req_ready_o), 64'(0));
        fork
            send(1'b0, 1'b0, 2'd3, 39'h108, 64'h0, 3'd4, 64'hDEAD_BEEF_0000_ABCD);
        join_none
        for (int i = 0; i < 3; i++) begin
            check("hold_valid", 64'(resp_valid_o), 64'(1));
            check("hold_tag", 64'(resp_lsq_index_o), 64'(0));
            check("hold_data", resp_data_o, 64'h1122_3344_8066_7788);
            check("hold_ready_low", 64'(req_ready_o), 64'(0));
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        resp_ready_i = 1'b1;
        pop_edge = cyc + 1;
        pops_before = pops;
        @(posedge clk);
        #1;
        resp_ready_i = 1'b0;
        @(negedge clk);
        check("one_pop", 64'(pops - pops_before), 64'(1));
        check("next_head_tag", 64'(resp_lsq_index_o), 64'(1));
        @(posedge clk);
        #1;
        check("fifth_accept_edge", 64'(last_acc), 64'(pop_edge + 1));
        resp_ready_i = 1'b1;
        wait_drain();
        lat_chk = 1'b1;

        // reset with three outstanding entries; the store must survive it
        resp_ready_i = 1'b0;
        send(1'b1, 1'b0, 2'd3, 39'h200, 64'hCAFE_F00D_1234_5678, 3'd1, 64'h0);
        send(1'b0, 1'b0, 2'd3, 39'h200, 64'h0, 3'd2, 64'hCAFE_F00D_1234_5678);
        send(1'b0, 1'b0, 2'd1, 39'h200, 64'h0, 3'd3, 64'h5678);
        @(negedge clk);
        check("pre_reset_valid", 64'(resp_valid_o), 64'(1));
        #1;
        rstn = 1'b0;
        #1;
        check("mid_rst_valid", 64'(resp_valid_o), 64'(0));
        check("mid_rst_ready", 64'(req_ready_o), 64'(1));
        check("mid_rst_data", resp_data_o, 64'h0);
        check("mid_rst_tag", 64'(resp_lsq_index_o), 64'(0));
        check("mid_rst_store", 64'(resp_store_o), 64'(0));
        exp_q.delete();
        acc_q.delete();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        resp_ready_i = 1'b1;
        send(1'b0, 1'b0, 2'd3, 39'h200, 64'h0, 3'd6, 64'hCAFE_F00D_1234_5678);
        wait_drain();

        // back-to-back load burst, tags must come back in issue order
        for (int i = 0; i < 16; i++) begin
            send(1'b0, 1'b0, 2'd3, 39'h100, 64'h0, 3'(i), 64'h1122_3344_8066_7788);
        end
        wait_drain();
        check("total_pops", 64'(pops), 64'(36));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
